// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the fetch PC / redirect stage.
// Holds the FSM state encodings and the state width. The encodings are also
// driven out on the pc_branch_unit state port, so they must not change.
package pc_branch_unit_pkg;

  localparam int PC_STATE_W = 2;

  typedef enum logic [PC_STATE_W-1:0] {
    PC_RUN   = 2'd0,
    PC_FLUSH = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Purpose : PC-relative branch/jump target, br_pc + signed offset, modulo 2^PC_W.
// Latency : combinational, no registers.
// Backpressure: none, pure function of its inputs.
// Ports   : i_br_pc    - PC of the resolving branch/jump
//           i_br_offset - two's-complement offset
//           o_target   - wrapped target PC
module pc_target_adder #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] i_br_pc,
  input  logic [PC_W-1:0] i_br_offset,
  output logic [PC_W-1:0] o_target
);

  // Unsigned addition of a two's-complement offset gives the signed result,
  // and dropping the carry gives the modulo-2^PC_W wrap.
  assign o_target = i_br_pc + i_br_offset;

endmodule

// File: rtl/pc_branch_unit.sv
// Purpose : fetch PC register with branch/jump redirect, wrong-path flush and HALT.
// Latency : all outputs registered; a redirect shows on pc/redirect one cycle after resolve.
// Backpressure: stall holds pc; a redirect overrides stall; the flush window length ignores stall.
// Ports   : clk, rst (sync, active high); stall, halt, br_valid, cond_true,
//           jmp_valid, br_pc, br_offset in; pc, fetch_en, flush, redirect,
//           state, taken_cnt out.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int            PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int            FLUSH_CYCLES = 2,
  parameter int            CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  br_valid,
  input  logic                  cond_true,
  input  logic                  jmp_valid,
  input  logic [PC_W-1:0]       br_pc,
  input  logic [PC_W-1:0]       br_offset,
  output logic [PC_W-1:0]       pc,
  output logic                  fetch_en,
  output logic                  flush,
  output logic                  redirect,
  output logic [PC_STATE_W-1:0] state,
  output logic [CNT_W-1:0]      taken_cnt
);

  generate
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
      $error("pc_branch_unit: FLUSH_CYCLES must be >= 1");
    end
  endgenerate

  // The flush counter only has to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  pc_state_e         r_state,    w_nxt_state;
  logic [PC_W-1:0]   r_pc,       w_nxt_pc;
  logic              r_fetch_en, w_nxt_fetch_en;
  logic              r_flush,    w_nxt_flush;
  logic              r_redirect, w_nxt_redirect;
  logic [FC_W-1:0]   r_cnt,      w_nxt_cnt;
  logic [CNT_W-1:0]  r_taken,    w_nxt_taken;

  logic [PC_W-1:0]   w_target;
  logic              w_req;
  logic              w_br_taken;

  pc_target_adder #(.PC_W(PC_W)) u_target (
    .i_br_pc     (br_pc),
    .i_br_offset (br_offset),
    .o_target    (w_target)
  );

  assign w_br_taken = br_valid & cond_true;
  assign w_req      = w_br_taken | jmp_valid;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_pc       = r_pc;
    w_nxt_fetch_en = r_fetch_en;
    w_nxt_flush    = 1'b0;
    w_nxt_redirect = 1'b0;
    w_nxt_cnt      = r_cnt;
    w_nxt_taken    = r_taken;

    case (r_state)
      PC_RUN: begin
        w_nxt_fetch_en = 1'b1;
        if (halt) begin
          // halt beats a same-cycle branch; the branch is dropped.
          w_nxt_state    = PC_HALT;
          w_nxt_fetch_en = 1'b0;
        end else if (w_req) begin
          w_nxt_pc       = w_target;
          w_nxt_redirect = 1'b1;
          w_nxt_flush    = 1'b1;
          w_nxt_cnt      = FC_LOAD;
          w_nxt_state    = PC_FLUSH;
        end else if (!stall) begin
          w_nxt_pc = r_pc + PC_W'(1);
        end
        if (w_br_taken && !halt && (r_taken != {CNT_W{1'b1}})) begin
          w_nxt_taken = r_taken + CNT_W'(1);
        end
      end
      PC_FLUSH: begin
        // Resolves arriving now are wrong-path and deliberately ignored.
        w_nxt_fetch_en = 1'b1;
        if (!stall) begin
          w_nxt_pc = r_pc + PC_W'(1);
        end
        if (r_cnt == '0) begin
          w_nxt_state = PC_RUN;
        end else begin
          w_nxt_cnt   = r_cnt - FC_W'(1);
          w_nxt_flush = 1'b1;
        end
      end
      PC_HALT: begin
        w_nxt_fetch_en = 1'b0;
      end
      default: begin
        // Unused encoding: fall back to RUN without touching pc.
        w_nxt_state    = PC_RUN;
        w_nxt_fetch_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PC_RUN;
      r_pc       <= RESET_PC;
      r_fetch_en <= 1'b1;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_cnt      <= '0;
      r_taken    <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_pc       <= w_nxt_pc;
      r_fetch_en <= w_nxt_fetch_en;
      r_flush    <= w_nxt_flush;
      r_redirect <= w_nxt_redirect;
      r_cnt      <= w_nxt_cnt;
      r_taken    <= w_nxt_taken;
    end
  end

  assign pc        = r_pc;
  assign fetch_en  = r_fetch_en;
  assign flush     = r_flush;
  assign redirect  = r_redirect;
  assign state     = r_state;
  assign taken_cnt = r_taken;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset, sequential fetch, taken/not-taken
// branches, redirect under stall, wrong-path squash, PC wrap, halt and re-reset.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, halt, br_valid, cond_true, jmp_valid;
  logic [15:0] br_pc, br_offset;
  logic [15:0] pc;
  logic        fetch_en, flush, redirect;
  logic [1:0]  state;
  logic [15:0] taken_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .halt      (halt),
    .br_valid  (br_valid),
    .cond_true (cond_true),
    .jmp_valid (jmp_valid),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .redirect  (redirect),
    .state     (state),
    .taken_cnt (taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_fe,
                         input logic e_fl, input logic e_rd, input logic [1:0] e_st,
                         input logic [15:0] e_cnt);
    chk({tag, ".pc"},        32'(pc),        32'(e_pc));
    chk({tag, ".fetch_en"},  32'(fetch_en),  32'(e_fe));
    chk({tag, ".flush"},     32'(flush),     32'(e_fl));
    chk({tag, ".redirect"},  32'(redirect),  32'(e_rd));
    chk({tag, ".state"},     32'(state),     32'(e_st));
    chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(e_cnt));
  endtask

  task automatic idle_inputs();
    stall = 0; halt = 0; br_valid = 0; cond_true = 0; jmp_valid = 0;
    br_pc = 16'h0; br_offset = 16'h0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();

    // Reset for two edges.
    step(); chk_all("rst0", 16'h0000, 1, 0, 0, 0, 0);
    step(); chk_all("rst1", 16'h0000, 1, 0, 0, 0, 0);
    rst = 0;

    // Sequential fetch.
    step(); chk_all("seq1", 16'h0001, 1, 0, 0, 0, 0);
    step(); chk_all("seq2", 16'h0002, 1, 0, 0, 0, 0);
    step(); chk_all("seq3", 16'h0003, 1, 0, 0, 0, 0);
    step(); chk_all("seq4", 16'h0004, 1, 0, 0, 0, 0);
    step(); chk_all("seq5", 16'h0005, 1, 0, 0, 0, 0);

    // Taken conditional branch: 4 + (-2) = 2.
    br_valid = 1; cond_true = 1; br_pc = 16'h0004; br_offset = 16'hFFFE;
    step(); chk_all("br_taken", 16'h0002, 1, 1, 1, 1, 1);
    idle_inputs();
    step(); chk_all("br_flush2", 16'h0003, 1, 1, 0, 1, 1);
    step(); chk_all("br_done",   16'h0004, 1, 0, 0, 0, 1);
    step(); chk_all("seq_a",     16'h0005, 1, 0, 0, 0, 1);
    step(); chk_all("seq_b",     16'h0006, 1, 0, 0, 0, 1);
    step(); chk_all("seq_c",     16'h0007, 1, 0, 0, 0, 1);

    // Not-taken branch.
    br_valid = 1; cond_true = 0; br_pc = 16'h0007; br_offset = 16'h0040;
    step(); chk_all("br_nt", 16'h0008, 1, 0, 0, 0, 1);

    // Jump under stall: 0x10 + 0x20 = 0x30, redirect beats stall.
    stall = 1; br_valid = 0; jmp_valid = 1; br_pc = 16'h0010; br_offset = 16'h0020;
    step(); chk_all("jmp_stall", 16'h0030, 1, 1, 1, 1, 1);

    // Wrong-path taken branch in first FLUSH cycle: ignored.
    jmp_valid = 0; br_valid = 1; cond_true = 1; br_pc = 16'h0030; br_offset = 16'h0100;
    step(); chk_all("squash", 16'h0030, 1, 1, 0, 1, 1);
    br_valid = 0; cond_true = 0;
    step(); chk_all("stall_done", 16'h0030, 1, 0, 0, 0, 1);
    step(); chk_all("stall_hold", 16'h0030, 1, 0, 0, 0, 1);
    stall = 0;

    // Jump with wrapping target: 0xFFFF + (-2) = 0xFFFD.
    jmp_valid = 1; br_pc = 16'hFFFF; br_offset = 16'hFFFE;
    step(); chk_all("jmp_wrap", 16'hFFFD, 1, 1, 1, 1, 1);
    idle_inputs();
    step(); chk_all("jw_fl2",  16'hFFFE, 1, 1, 0, 1, 1);
    step(); chk_all("jw_done", 16'hFFFF, 1, 0, 0, 0, 1);
    step(); chk_all("pc_wrap", 16'h0000, 1, 0, 0, 0, 1);
    step(); chk_all("pc_one",  16'h0001, 1, 0, 0, 0, 1);

    // Halt together with jump and taken branch: halt wins, nothing counted.
    halt = 1; jmp_valid = 1; br_valid = 1; cond_true = 1; br_pc = 16'h0100; br_offset = 16'h0004;
    step(); chk_all("halt", 16'h0001, 0, 0, 0, 2, 1);
    halt = 0;
    step(); chk_all("halt_hold1", 16'h0001, 0, 0, 0, 2, 1);
    idle_inputs();
    step(); chk_all("halt_hold2", 16'h0001, 0, 0, 0, 2, 1);

    // Reset out of HALT.
    rst = 1;
    step(); chk_all("rst_halt", 16'h0000, 1, 0, 0, 0, 0);
    rst = 0;
    step(); chk_all("post_rst", 16'h0001, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
